// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: bridges the asynchronous 68000 bus (AS/UDS/LDS/RW/DTACK) to a 16-bit
// word ram without byte enables. It sequences the ram enable/write strobes and data bus,
// inserts WAIT_STATES extra enable clocks per access, runs single-byte writes as
// read-modify-write, and generates a registered DTACK.
module ram_bus_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cs,
    input  logic [ADDR_WIDTH:0]   i_cpu_addr,
    input  logic                  i_cpu_as_n,
    input  logic                  i_cpu_uds_n,
    input  logic                  i_cpu_lds_n,
    input  logic                  i_cpu_rw,
    input  logic [DATA_WIDTH-1:0] i_cpu_data,
    output logic [DATA_WIDTH-1:0] o_cpu_data,
    output logic                  o_cpu_data_oe,
    output logic                  o_cpu_dtack_n,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_enable,
    output logic                  o_ram_write,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_data_oe,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    localparam int unsigned HalfW   = DATA_WIDTH / 2;
    localparam logic [3:0]  WaitMax = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        StIdle,  // waiting for a selected bus cycle
        StRd,    // ram read (plain read or first half of read-modify-write)
        StWs,    // write setup: write and bus drive up, enable low
        StWe,    // write enable pulse, ram commits on its rising edge
        StWh,    // write hold: enable low, write and bus drive still up
        StAck    // DTACK asserted until the CPU drops AS
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [3:0]             r_wait;
    logic [3:0]             w_wait_d;
    logic                   r_abort;
    logic                   w_abort_d;

    logic [SYNC_STAGES-1:0] r_as_sync;
    logic [SYNC_STAGES-1:0] r_uds_sync;
    logic [SYNC_STAGES-1:0] r_lds_sync;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_rw;
    logic                   r_uds;
    logic                   r_lds;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_dtack_n;
    logic                   r_cpu_oe;

    logic                   w_as_act;
    logic                   w_uds_act;
    logic                   w_lds_act;
    logic                   w_start;
    logic                   w_wait_done;
    logic                   w_cpu_gone;
    logic                   w_ack_live;
    logic                   w_unused_addr0;

    // Byte address bit 0 carries no information on a 16-bit bus.
    assign w_unused_addr0 = i_cpu_addr[0];

    assign w_as_act    = ~r_as_sync[SYNC_STAGES-1];
    assign w_uds_act   = ~r_uds_sync[SYNC_STAGES-1];
    assign w_lds_act   = ~r_lds_sync[SYNC_STAGES-1];
    assign w_start     = w_as_act & i_cs & (w_uds_act | w_lds_act);
    assign w_wait_done = (r_wait == WaitMax);
    // CPU withdrew the cycle, now or at some point earlier in this access.
    assign w_cpu_gone  = r_abort | ~w_as_act;
    assign w_ack_live  = (r_state == StAck) & w_as_act;

    // Bring the asynchronous strobes into the clock domain (idle high).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_as_sync  <= '1;
            r_uds_sync <= '1;
            r_lds_sync <= '1;
        end else begin
            r_as_sync  <= {r_as_sync[SYNC_STAGES-2:0], i_cpu_as_n};
            r_uds_sync <= {r_uds_sync[SYNC_STAGES-2:0], i_cpu_uds_n};
            r_lds_sync <= {r_lds_sync[SYNC_STAGES-2:0], i_cpu_lds_n};
        end
    end

    // FSM state, wait counter and abort flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_wait  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            r_abort <= w_abort_d;
        end
    end

    // Next-state logic and ram strobe decode.
    always_comb begin
        w_state_d     = r_state;
        w_wait_d      = r_wait;
        w_abort_d     = r_abort;
        o_ram_enable  = 1'b0;
        o_ram_write   = 1'b0;
        o_ram_data_oe = 1'b0;

        // An abort never truncates the ram sequence; it only suppresses the ACK.
        if ((r_state != StIdle) && (r_state != StAck) && !w_as_act) begin
            w_abort_d = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                w_abort_d = 1'b0;
                w_wait_d  = '0;
                if (w_start) begin
                    if (!i_cpu_rw && w_uds_act && w_lds_act) begin
                        w_state_d = StWs;
                    end else begin
                        w_state_d = StRd;
                    end
                end
            end
            StRd: begin
                o_ram_enable = 1'b1;
                if (w_wait_done) begin
                    w_wait_d = '0;
                    if (!r_rw) begin
                        w_state_d = StWs;
                    end else if (w_cpu_gone) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StAck;
                    end
                end else begin
                    w_wait_d = r_wait + 4'd1;
                end
            end
            StWs: begin
                o_ram_write   = 1'b1;
                o_ram_data_oe = 1'b1;
                w_state_d     = StWe;
            end
            StWe: begin
                o_ram_enable  = 1'b1;
                o_ram_write   = 1'b1;
                o_ram_data_oe = 1'b1;
                if (w_wait_done) begin
                    w_wait_d  = '0;
                    w_state_d = StWh;
                end else begin
                    w_wait_d = r_wait + 4'd1;
                end
            end
            StWh: begin
                o_ram_write   = 1'b1;
                o_ram_data_oe = 1'b1;
                w_state_d     = w_cpu_gone ? StIdle : StAck;
            end
            StAck: begin
                if (!w_as_act) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Latch the bus cycle, capture/merge ram data, and register DTACK and CPU drive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_uds     <= 1'b0;
            r_lds     <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_dtack_n <= 1'b1;
            r_cpu_oe  <= 1'b0;
        end else begin
            if ((r_state == StIdle) && w_start) begin
                r_addr  <= i_cpu_addr[ADDR_WIDTH:1];
                r_rw    <= i_cpu_rw;
                r_uds   <= w_uds_act;
                r_lds   <= w_lds_act;
                r_wdata <= i_cpu_data;
            end
            if ((r_state == StRd) && w_wait_done) begin
                if (r_rw) begin
                    r_rdata <= i_ram_data;
                end else begin
                    // Keep the CPU byte on its lane, refill the other from the ram.
                    if (!r_uds) begin
                        r_wdata[DATA_WIDTH-1:HalfW] <= i_ram_data[DATA_WIDTH-1:HalfW];
                    end
                    if (!r_lds) begin
                        r_wdata[HalfW-1:0] <= i_ram_data[HalfW-1:0];
                    end
                end
            end
            r_dtack_n <= ~w_ack_live;
            r_cpu_oe  <= w_ack_live & r_rw;
        end
    end

    assign o_ram_addr    = r_addr;
    assign o_ram_data    = r_wdata;
    assign o_cpu_data    = r_rdata;
    assign o_cpu_dtack_n = r_dtack_n;
    assign o_cpu_data_oe = r_cpu_oe;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// tb_ram_bus_ctrl: drives 68000-style bus cycles into ram_bus_ctrl, models the word ram,
// and checks DTACK timing, read data and strobe invariants against a reference memory.
module tb_ram_bus_ctrl;

    localparam int unsigned AW   = 16;
    localparam int unsigned W    = 1;
    localparam int unsigned SYNC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic [AW:0]   cpu_addr = '0;
    logic          as_n = 1'b1;
    logic          uds_n = 1'b1;
    logic          lds_n = 1'b1;
    logic          rw = 1'b1;
    logic [15:0]   cpu_wdata = '0;
    logic [15:0]   cpu_rdata;
    logic          cpu_oe;
    logic          dtack_n;
    logic [AW-1:0] ram_addr;
    logic          ram_enable;
    logic          ram_write;
    logic [15:0]   ram_wdata;
    logic          ram_data_oe;
    logic [15:0]   ram_rdata;

    ram_bus_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (16),
        .WAIT_STATES (W),
        .SYNC_STAGES (SYNC)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cs          (cs),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_as_n    (as_n),
        .i_cpu_uds_n   (uds_n),
        .i_cpu_lds_n   (lds_n),
        .i_cpu_rw      (rw),
        .i_cpu_data    (cpu_wdata),
        .o_cpu_data    (cpu_rdata),
        .o_cpu_data_oe (cpu_oe),
        .o_cpu_dtack_n (dtack_n),
        .o_ram_addr    (ram_addr),
        .o_ram_enable  (ram_enable),
        .o_ram_write   (ram_write),
        .o_ram_data    (ram_wdata),
        .o_ram_data_oe (ram_data_oe),
        .i_ram_data    (ram_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0021) return 16'hBEEF;
        if (a == 16'h0030) return 16'h5566;
        return {a[7:0] ^ 8'hA5, ~a[7:0]};
    endfunction

    // Word ram: drives its bus while enabled for read, commits on enable rising edge.
    logic [15:0] ram_arr [0:65535];
    bit          ram_wr  [0:65535];
    int unsigned en_pulses = 0;
    assign ram_rdata = (ram_enable && !ram_write)
                     ? (ram_wr[ram_addr] ? ram_arr[ram_addr] : init_val(ram_addr)) : 16'h0BAD;

    always @(posedge ram_enable) begin
        en_pulses <= en_pulses + 1;
        if (ram_write) begin
            ram_arr[ram_addr] <= ram_wdata;
            ram_wr[ram_addr]  <= 1'b1;
        end
    end

    // Reference memory: what the CPU should observe.
    logic [15:0] ref_mem [0:65535];

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
        int unsigned due;
    } exp_t;
    exp_t exp_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard on every DTACK assertion and checks strobe invariants.
    logic          prev_dtack = 1'b1;
    logic          prev_write = 1'b0;
    logic          prev_busy  = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    int unsigned   en_hi = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            prev_dtack <= 1'b1;
            prev_write <= 1'b0;
            prev_busy  <= 1'b0;
        end else begin
            if (prev_dtack && !dtack_n) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_dtack");
                end else begin
                    e = exp_q.pop_front();
                    check("dtack_cycle", cyc, e.due);
                    check("cpu_data_oe", {31'd0, cpu_oe}, {31'd0, e.is_rd});
                    if (e.is_rd) check("read_data", {16'd0, cpu_rdata}, {16'd0, e.data});
                end
            end
            if (ram_data_oe) check("oe_implies_write", {31'd0, ram_write}, 32'd1);
            if (ram_write !== prev_write) check("write_edge_enable_low", {31'd0, ram_enable}, 32'd0);
            if (prev_busy && (ram_enable || ram_write))
                check("addr_stable", {16'd0, ram_addr}, {16'd0, prev_addr});
            if (ram_enable) en_hi <= en_hi + 1;
            prev_dtack <= dtack_n;
            prev_write <= ram_write;
            prev_busy  <= ram_enable | ram_write;
            prev_addr  <= ram_addr;
        end
    end

    // One complete bus cycle; expected response goes to the scoreboard.
    task automatic run_cycle(input bit rd, input logic [15:0] wa, input logic [1:0] lanes,
                             input logic [15:0] wd, input int unsigned hold);
        int unsigned n, m, lat;
        exp_t e;
        bit got;
        @(negedge clk);
        cs = 1'b1;
        cpu_addr = {wa, 1'b0};
        rw = rd;
        cpu_wdata = wd;
        uds_n = ~lanes[1];
        lds_n = ~lanes[0];
        as_n = 1'b0;
        n = cyc;
        if (rd) lat = W + 2;
        else if (lanes == 2'b11) lat = W + 4;
        else lat = 2 * W + 5;
        e.is_rd = rd;
        e.due = n + SYNC + 1 + lat;
        e.data = '0;
        if (rd) begin
            e.data = ref_mem[wa];
        end else begin
            if (lanes[1]) ref_mem[wa][15:8] = wd[15:8];
            if (lanes[0]) ref_mem[wa][7:0]  = wd[7:0];
        end
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dtack_n) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("dtack_timeout");
        repeat (hold) @(negedge clk);
        as_n = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        m = cyc;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dtack_n) begin
                got = 1'b1;
                break;
            end
        end
        if (got) check("dtack_release", cyc, m + SYNC + 1);
        else flag("release_timeout");
        check("cpu_oe_release", {31'd0, cpu_oe}, 32'd0);
        cs = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int unsigned snap, p0, kind;
        logic [1:0]  ln;
        bit          got;
        for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(16'(a));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dtack_n", {31'd0, dtack_n}, 32'd1);
        check("rst_enable", {31'd0, ram_enable}, 32'd0);
        check("rst_write", {31'd0, ram_write}, 32'd0);
        check("rst_ram_oe", {31'd0, ram_data_oe}, 32'd0);
        check("rst_cpu_oe", {31'd0, cpu_oe}, 32'd0);
        check("rst_cpu_data", {16'd0, cpu_rdata}, 32'd0);
        check("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word read at byte address 0x0042
        snap = en_hi;
        run_cycle(1'b1, 16'h0021, 2'b11, 16'h0000, 0);
        check("read_enable_clocks", en_hi - snap, W + 1);

        // Word write then readback
        run_cycle(1'b0, 16'h0008, 2'b11, 16'h1234, 1);
        run_cycle(1'b1, 16'h0008, 2'b11, 16'h0000, 0);

        // Upper-byte write into a word holding 0x5566
        snap = en_hi;
        run_cycle(1'b0, 16'h0030, 2'b10, 16'hAB00, 0);
        check("rmw_enable_clocks", en_hi - snap, 2 * (W + 1));
        run_cycle(1'b1, 16'h0030, 2'b11, 16'h0000, 0);
        check("rmw_result", {16'd0, ref_mem[16'h0030]}, 32'h0000AB66);

        // Abort: AS held for one clock only on a word write
        @(negedge clk);
        cs = 1'b1; cpu_addr = {16'h0005, 1'b0}; rw = 1'b0; cpu_wdata = 16'h7A7A;
        uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        p0 = en_pulses;
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        repeat (W + 12) @(negedge clk);
        check("abort_enable_pulses", en_pulses - p0, 1);
        check("abort_no_dtack", {31'd0, dtack_n}, 32'd1);
        cs = 1'b0;
        ref_mem[16'h0005] = 16'h7A7A;
        run_cycle(1'b1, 16'h0005, 2'b11, 16'h0000, 0);

        // Reset asserted while the write enable pulse is up
        @(negedge clk);
        cs = 1'b1; cpu_addr = {16'h0012, 1'b0}; rw = 1'b0; cpu_wdata = 16'hC0DE;
        uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_enable && ram_write) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("reach_write_enable");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_enable", {31'd0, ram_enable}, 32'd0);
        check("midrst_write", {31'd0, ram_write}, 32'd0);
        check("midrst_ram_oe", {31'd0, ram_data_oe}, 32'd0);
        check("midrst_dtack_n", {31'd0, dtack_n}, 32'd1);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; cs = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Enable had already risen, so the ram committed the word.
        ref_mem[16'h0012] = 16'hC0DE;
        repeat (2) @(negedge clk);
        run_cycle(1'b1, 16'h0012, 2'b11, 16'h0000, 0);
        run_cycle(1'b1, 16'h0021, 2'b11, 16'h0000, 0);

        // Cycle not selected: nothing happens on the ram side
        @(negedge clk);
        cs = 1'b0; rw = 1'b1; cpu_addr = {16'h0003, 1'b0};
        uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        p0 = en_pulses;
        repeat (10) @(negedge clk);
        check("nocs_enable_pulses", en_pulses - p0, 0);
        check("nocs_dtack_n", {31'd0, dtack_n}, 32'd1);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        repeat (4) @(negedge clk);

        // Randomized traffic over a small address window
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    ln = 2'($urandom_range(1, 3));
                    run_cycle(1'b1, 16'($urandom_range(0, 31)), ln, 16'h0000,
                              $urandom_range(0, 2));
                end
                1: run_cycle(1'b0, 16'($urandom_range(0, 31)), 2'b11, 16'($urandom),
                             $urandom_range(0, 2));
                2: run_cycle(1'b0, 16'($urandom_range(0, 31)), 2'b10, 16'($urandom),
                             $urandom_range(0, 2));
                default: run_cycle(1'b0, 16'($urandom_range(0, 31)), 2'b01, 16'($urandom),
                                   $urandom_range(0, 2));
            endcase
        end
        for (int a = 0; a < 32; a++) run_cycle(1'b1, 16'(a), 2'b11, 16'h0000, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
